hazard_controller: RTL
======================

// Module: hazard_controller
// PURPOSE
//  Pipeline hazard/sequencing controller for the 5-stage RV32I core. Computes EX operand
//  forwarding selects and the stall/flush enables for IF/ID/EX/MEM/WB pipeline registers.
//  Handles load-use stalls, taken-branch/jump flushes, multi-cycle data-memory waits
//  (with timeout detection) and a post-reset bubble sequence. Keeps saturating perf counters.
// PARAMETERS
//  RST_FLUSH_CYC  2    cycles FlushD/FlushE held after reset release (>=1)
//  MEM_TIMEOUT    255  max wait cycles for dmem_ready before mem_timeout sets (>=1)
//  CNT_W          32   width of perf counters
// PORTS
//  clk             in   1      clock, rising edge
//  reset           in   1      asynchronous, active-high
//  Rs1D, Rs2D      in   5      source regs of instruction in ID
//  Rs1E, Rs2E, RdE in   5      source/dest regs of instruction in EX
//  MemReadE        in   1      EX instruction is a load
//  PCSrcE          in   1      EX branch taken or jump/jalr (redirect)
//  RdM, RdW        in   5      dest regs in MEM / WB
//  RegWriteM/W     in   1      MEM / WB instruction writes RF
//  MemAccessM      in   1      MEM instruction accesses data memory
//  dmem_ready      in   1      data memory completes access this cycle
//  ForwardAE/BE    out  2      00=RF, 10=ALU result from MEM, 01=result from WB
//  StallF, StallD  out  1      hold PC / IF-ID register
//  StallE, StallM  out  1      hold ID-EX / EX-MEM register
//  FlushD, FlushE  out  1      bubble IF-ID / ID-EX register
//  FlushW          out  1      bubble MEM-WB register
//  mem_timeout     out  1      sticky: a memory wait exceeded MEM_TIMEOUT
//  stall_cnt       out  CNT_W  cycles with StallF=1 (excluding RST_FLUSH)
//  flush_cnt       out  CNT_W  redirect flushes taken
// BEHAVIOUR
//  Forwarding (combinational, all states): ForwardAE=10 if RegWriteM && RdM!=0 && RdM==Rs1E;
//   else 01 if RegWriteW && RdW!=0 && RdW==Rs1E; else 00. MEM beats WB. ForwardBE same on Rs2E.
//  lwStall  = MemReadE && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
//  memStall = MemAccessM && !dmem_ready.
//  FSM states RST_FLUSH, RUN, MEM_WAIT; wait counter wcnt (width clog2(MEM_TIMEOUT+1)).
//  Reset asserted (async): state=RST_FLUSH, rcnt=0, wcnt=0, mem_timeout=0, counters=0.
//   Outputs in RST_FLUSH: StallF=1, FlushD=1, FlushE=1, all others 0, ForwardAE/BE per rule.
//  RST_FLUSH: rcnt increments; after RST_FLUSH_CYC cycles -> RUN. PCSrcE/memStall ignored.
//  RUN, outputs (priority top-down, combinational from state+inputs):
//   1 memStall: StallF=StallD=StallE=StallM=1, FlushW=1; PCSrcE/lwStall not acted on; ->MEM_WAIT, wcnt=1.
//   2 PCSrcE: FlushD=FlushE=1; flush_cnt++; lwStall ignored (redirected instr is squashed).
//   3 lwStall: StallF=StallD=1, FlushE=1 (exactly one bubble; next cycle load is in MEM).
//   4 else all stall/flush 0.
//  MEM_WAIT: same outputs as RUN case 1 while !dmem_ready; wcnt++ (saturates).
//   wcnt reaching MEM_TIMEOUT sets mem_timeout (sticky until reset); wait continues.
//   dmem_ready=1: MEM releases this cycle; outputs evaluated as RUN cases 2-4; ->RUN, wcnt=0.
//   MemAccessM deasserted in MEM_WAIT treated as dmem_ready=1.
//  stall_cnt increments every cycle StallF=1 in RUN/MEM_WAIT; counters saturate at all-ones.
//  Reset mid-MEM_WAIT: immediate return to RST_FLUSH, mem_timeout cleared.
//  No X on outputs after reset even with X inputs in RST_FLUSH except Forward*.
// TESTING
//  1 Reset 3 cycles, release -> FlushD=FlushE=StallF=1 for exactly 2 cycles, then all 0, counters 0.
//  2 RdM=5,RegWriteM=1,RdW=5,RegWriteW=1,Rs1E=5 -> ForwardAE=10; RdM=0 same -> ForwardAE=01;
//    Rs2E=0 with RdW=0 -> ForwardBE=00.
//  3 MemReadE=1,RdE=7,Rs2D=7 one cycle -> StallF=StallD=FlushE=1 one cycle, stall_cnt=1.
//  4 PCSrcE=1 with lwStall true same cycle -> FlushD=FlushE=1, StallF=0, flush_cnt=1.
//  5 MemAccessM=1, dmem_ready low 4 cycles then high -> StallF..StallM=FlushW=1 for 4 cycles,
//    released cycle 5, stall_cnt=4, mem_timeout=0.
//  6 MEM_TIMEOUT=3, dmem_ready low 10 cycles -> mem_timeout=1 from 3rd wait cycle, stays 1
//    after ready; assert reset mid-wait -> mem_timeout=0, state RST_FLUSH.

Source files
------------

// File: rtl/hazard_if.sv
// Signal bundle between the RV32I pipeline datapath and its hazard/sequencing controller.
// The datapath side is the master; the controller is the slave.
interface hazard_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       Rs1D;
  logic [4:0]       Rs2D;
  logic [4:0]       Rs1E;
  logic [4:0]       Rs2E;
  logic [4:0]       RdE;
  logic             MemReadE;
  logic             PCSrcE;
  logic [4:0]       RdM;
  logic [4:0]       RdW;
  logic             RegWriteM;
  logic             RegWriteW;
  logic             MemAccessM;
  logic             dmem_ready;

  logic [1:0]       ForwardAE;
  logic [1:0]       ForwardBE;
  logic             StallF;
  logic             StallD;
  logic             StallE;
  logic             StallM;
  logic             FlushD;
  logic             FlushE;
  logic             FlushW;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, MemReadE, PCSrcE,
           RdM, RdW, RegWriteM, RegWriteW, MemAccessM, dmem_ready,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
           FlushD, FlushE, FlushW, mem_timeout, stall_cnt, flush_cnt
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, MemReadE, PCSrcE,
           RdM, RdW, RegWriteM, RegWriteW, MemAccessM, dmem_ready,
    output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
           FlushD, FlushE, FlushW, mem_timeout, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_controller.sv
// Hazard controller for the 5-stage RV32I core: EX forwarding selects, pipeline
// stall/flush enables, data-memory wait tracking with timeout, and perf counters.
//
// state     | meaning
// RST_FLUSH | post-reset bubbles: PC held, ID/EX flushed for RST_FLUSH_CYC cycles
// RUN       | normal issue; load-use stalls and redirect flushes
// MEM_WAIT  | MEM access outstanding; whole pipe frozen, WB bubbled
module hazard_controller #(
  parameter int RST_FLUSH_CYC = 2,
  parameter int MEM_TIMEOUT   = 255,
  parameter int CNT_W         = 32
) (
  input  logic     clk,
  input  logic     reset,
  hazard_if.slave  hz
);

  typedef enum logic [1:0] {
    RST_FLUSH = 2'd0,
    RUN       = 2'd1,
    MEM_WAIT  = 2'd2
  } state_t;

  localparam int RW = (RST_FLUSH_CYC > 1) ? $clog2(RST_FLUSH_CYC) : 1;
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [RW-1:0] RLAST = RW'(RST_FLUSH_CYC - 1);
  localparam logic [WW-1:0] WMAX  = WW'(MEM_TIMEOUT);

  state_t           state, state_nxt;
  logic [RW-1:0]    rcnt;
  logic [WW-1:0]    wcnt, wcnt_nxt;
  logic             mem_timeout_q;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  logic             lw_stall, mem_stall;
  logic             stall_f, stall_d, stall_e, stall_m;
  logic             flush_d, flush_e, flush_w;
  logic             flush_inc;
  logic [1:0]       fwd_a, fwd_b;

  // MEM result is newer than WB, so it wins when both match.
  always_comb begin
    fwd_a = 2'b00;
    if (hz.RegWriteM && hz.RdM != 5'd0 && hz.RdM == hz.Rs1E)      fwd_a = 2'b10;
    else if (hz.RegWriteW && hz.RdW != 5'd0 && hz.RdW == hz.Rs1E) fwd_a = 2'b01;
    fwd_b = 2'b00;
    if (hz.RegWriteM && hz.RdM != 5'd0 && hz.RdM == hz.Rs2E)      fwd_b = 2'b10;
    else if (hz.RegWriteW && hz.RdW != 5'd0 && hz.RdW == hz.Rs2E) fwd_b = 2'b01;
  end

  assign lw_stall  = hz.MemReadE && hz.RdE != 5'd0 &&
                     (hz.RdE == hz.Rs1D || hz.RdE == hz.Rs2D);
  // Dropping MemAccessM mid-wait also ends the wait.
  assign mem_stall = hz.MemAccessM && !hz.dmem_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= RST_FLUSH;
      rcnt          <= '0;
      wcnt          <= '0;
      mem_timeout_q <= 1'b0;
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
      if (state == RST_FLUSH && rcnt != RLAST)
        rcnt <= rcnt + RW'(1);
      if (state != RST_FLUSH && mem_stall && wcnt_nxt == WMAX)
        mem_timeout_q <= 1'b1;
      if (state != RST_FLUSH && stall_f && stall_cnt_q != '1)
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_inc && flush_cnt_q != '1)
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    stall_f   = 1'b0;
    stall_d   = 1'b0;
    stall_e   = 1'b0;
    stall_m   = 1'b0;
    flush_d   = 1'b0;
    flush_e   = 1'b0;
    flush_w   = 1'b0;
    flush_inc = 1'b0;
    case (state)
      RST_FLUSH: begin
        stall_f = 1'b1;
        flush_d = 1'b1;
        flush_e = 1'b1;
        if (rcnt == RLAST) state_nxt = RUN;
      end
      RUN, MEM_WAIT: begin
        if (mem_stall) begin
          stall_f   = 1'b1;
          stall_d   = 1'b1;
          stall_e   = 1'b1;
          stall_m   = 1'b1;
          flush_w   = 1'b1;
          state_nxt = MEM_WAIT;
          if (state == RUN)       wcnt_nxt = WW'(1);
          else if (wcnt != WMAX)  wcnt_nxt = wcnt + WW'(1);
        end else begin
          state_nxt = RUN;
          wcnt_nxt  = '0;
          if (hz.PCSrcE) begin
            // The load-use victim sits on the wrong path and is squashed anyway.
            flush_d   = 1'b1;
            flush_e   = 1'b1;
            flush_inc = 1'b1;
          end else if (lw_stall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
          end
        end
      end
      default: state_nxt = RST_FLUSH;
    endcase
  end

  assign hz.ForwardAE   = fwd_a;
  assign hz.ForwardBE   = fwd_b;
  assign hz.StallF      = stall_f;
  assign hz.StallD      = stall_d;
  assign hz.StallE      = stall_e;
  assign hz.StallM      = stall_m;
  assign hz.FlushD      = flush_d;
  assign hz.FlushE      = flush_e;
  assign hz.FlushW      = flush_w;
  assign hz.mem_timeout = mem_timeout_q;
  assign hz.stall_cnt   = stall_cnt_q;
  assign hz.flush_cnt   = flush_cnt_q;

endmodule
